// File: rtl/msk_and_sched.sv
// msk_and_sched: round-robin scheduler that time-shares one external pipelined
// masked AND gadget between NREQ requesters.
//
// Each cycle at most one requester is granted. Its operand sharings are muxed
// share-wise onto the gadget inputs, and one randomness word is consumed.
// The grant tag travels down a LAT-deep delay line alongside the gadget. When
// the tag emerges, a one-hot response pulse tells the requester that g_out is
// its result.
//
// Parameters: d (shares per bit), count (bits per operand), NREQ (2..8),
//             LAT (gadget latency, 1..4).
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    per-requester handshake (ready is a one-hot grant)
//   req_ina/inb        operand sharings, requester i at slice i
//   rnd_valid/ready    gadget randomness handshake (ready == issue)
//   g_ina/g_inb        gadget operands (all-zero when not issuing)
//   g_out              gadget result, valid LAT cycles after issue
//   resp_valid         one-hot response pulse
//   resp_out           result sharing (wire from g_out)
//   flush              stop issuing and drain in-flight operations
//   busy               operation in flight, or still draining
// Optional feature: define MSK_SCHED_STATS_EN to add the stat_issue and
// stat_rndstall saturating counters.
module msk_and_sched #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*count*d-1:0]   req_ina,
    input  logic [NREQ*count*d-1:0]   req_inb,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    output logic [count*d-1:0]        g_ina,
    output logic [count*d-1:0]        g_inb,
    input  logic [count*d-1:0]        g_out,
    output logic [NREQ-1:0]           resp_valid,
    output logic [count*d-1:0]        resp_out,
    input  logic                      flush,
    output logic                      busy
`ifdef MSK_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issue,
    output logic [15:0]               stat_rndstall
`endif
);

    localparam int unsigned W     = count * d;
    localparam int unsigned TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] w_grant;
    logic             w_any_req;
    logic             w_issue;
    logic             w_pend_upstream;
    logic [LAT-1:0]   r_vld;
    logic [TAG_W-1:0] r_tag [LAT];

    // Requester index ofs positions after base, wrapping at NREQ.
    function automatic logic [TAG_W-1:0] rr_index(input logic [TAG_W-1:0] base,
                                                  input int unsigned ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NREQ) sum = sum - NREQ;
        return TAG_W'(sum);
    endfunction

    // Rotating-priority pick. The scan runs from the far end, so the
    // requester nearest to r_ptr is the last one written and wins.
    always_comb begin
        w_grant = r_ptr;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid[rr_index(r_ptr, unsigned'(k))]) begin
                w_grant = rr_index(r_ptr, unsigned'(k));
            end
        end
    end

    assign w_any_req = |req_valid;
    // flush blocks issue already in the cycle it is raised.
    assign w_issue   = (r_state == ST_RUN) && !flush && w_any_req && rnd_valid;
    assign rnd_ready = w_issue;

    always_comb begin
        req_ready = '0;
        if (w_issue) req_ready[w_grant] = 1'b1;
    end

    // Share-wise operand mux. Idle inputs are forced to zero so that sharings
    // of other requesters never toggle the gadget.
    assign g_ina = w_issue ? req_ina[32'(w_grant) * W +: W] : '0;
    assign g_inb = w_issue ? req_inb[32'(w_grant) * W +: W] : '0;

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant == TAG_W'(NREQ - 1)) ? '0 : w_grant + TAG_W'(1);
        end
    end

    // Tag delay line that matches the gadget latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 0; s < int'(LAT); s++) r_tag[s] <= '0;
        end else begin
            r_vld[0] <= w_issue;
            r_tag[0] <= w_grant;
            for (int s = 1; s < int'(LAT); s++) begin
                r_vld[s] <= r_vld[s-1];
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (r_vld[LAT-1]) resp_valid[r_tag[LAT-1]] = 1'b1;
    end

    assign resp_out = g_out;

    // Operations still behind the output stage. Once this is clear, the line
    // is empty after the current edge, because nothing issues while draining.
    assign w_pend_upstream = |(LAT'(r_vld << 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Drain control: leave DRAIN in the cycle of the last response, so busy
    // falls on the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (flush)            w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pend_upstream) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (!flush)           w_state_nxt = ST_RUN;
            default:                        w_state_nxt = ST_RUN;
        endcase
    end

    assign busy = ((r_state != ST_IDLE) && (|r_vld)) || (r_state == ST_DRAIN);

`ifdef MSK_SCHED_STATS_EN
    logic [15:0] r_stat_issue;
    logic [15:0] r_stat_rndstall;

    // Saturating issue count and randomness-starvation count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issue    <= '0;
            r_stat_rndstall <= '0;
        end else begin
            if (w_issue && (r_stat_issue != 16'hFFFF)) begin
                r_stat_issue <= r_stat_issue + 16'd1;
            end
            if ((r_state == ST_RUN) && w_any_req && !rnd_valid
                && (r_stat_rndstall != 16'hFFFF)) begin
                r_stat_rndstall <= r_stat_rndstall + 16'd1;
            end
        end
    end

    assign stat_issue    = r_stat_issue;
    assign stat_rndstall = r_stat_rndstall;
`endif

endmodule
